// File: rtl/knight_gfx_pkg.sv
// Shared constants, types and helpers for the knight sprite graphics path.
package knight_gfx_pkg;

    localparam int SPR_W       = 32;
    localparam int SPR_H       = 32;
    localparam int N_FRAMES    = 4;
    localparam int PIX_W       = 4;
    localparam int H_ACTIVE    = 640;
    localparam int H_TOTAL     = 800;
    localparam int V_TOTAL     = 525;

    localparam int COL_W       = $clog2(SPR_W);
    localparam int ROW_W       = $clog2(SPR_H);
    localparam int FRAME_W     = $clog2(N_FRAMES);
    localparam int FRAME_WORDS = SPR_W * SPR_H;
    localparam int ADDR_W      = $clog2(N_FRAMES * FRAME_WORDS);

    localparam logic [PIX_W-1:0] TRANSPARENT_IDX = {PIX_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Signed 11-bit offset lies in [0, size): negative offsets have the MSB
    // set, so a single unsigned compare rejects both sides of the window.
    function automatic logic in_window(input logic [10:0] off, input int size);
        return (off < 11'(size));
    endfunction

endpackage

// File: rtl/line_buffer_2x.sv
// Ping-pong sprite line buffer: two SPR_W-entry banks, one write port and
// one registered read port that also flags opaque pixels.
module line_buffer_2x
    import knight_gfx_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [COL_W-1:0] wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic             rd_bank,
    input  logic [COL_W-1:0] rd_addr,
    output logic [PIX_W-1:0] rd_data,
    output logic             rd_opaque
);

    logic [PIX_W-1:0] mem_r [0:1][0:SPR_W-1];
    logic [PIX_W-1:0] rd_data_r;
    logic             rd_opaque_r;

    // Storage write; contents need no reset because the line-hit flags gate display.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_bank][wr_addr] <= wr_data;
        end
    end

    // Registered read; a disabled read returns the transparent index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r   <= TRANSPARENT_IDX;
            rd_opaque_r <= 1'b0;
        end else if (rd_en) begin
            rd_data_r   <= mem_r[rd_bank][rd_addr];
            rd_opaque_r <= (mem_r[rd_bank][rd_addr] != TRANSPARENT_IDX);
        end else begin
            rd_data_r   <= TRANSPARENT_IDX;
            rd_opaque_r <= 1'b0;
        end
    end

    assign rd_data   = rd_data_r;
    assign rd_opaque = rd_opaque_r;

endmodule

// File: rtl/sprite_line_fetch.sv
// Knight sprite line fetcher: loads the next scanline's sprite row from ROM
// during horizontal blank and streams palette indices during active video.
module sprite_line_fetch
    import knight_gfx_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic [9:0]         SprX,
    input  logic [9:0]         SprY,
    input  logic [FRAME_W-1:0] frame_sel,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [PIX_W-1:0]   rom_data,
    output logic [PIX_W-1:0]   pix_idx,
    output logic               pix_valid
);

    // Fetch-side state
    fetch_state_t       state_r;
    logic [COL_W-1:0]   col_r;
    logic [ADDR_W-1:0]  base_r;
    logic [ADDR_W-1:0]  rom_addr_r;
    logic [1:0]         line_hit_r;
    logic               wbank_r;
    logic               issue_v_r;
    logic [COL_W-1:0]   issue_col_r;
    logic               wr_v_r;
    logic [COL_W-1:0]   wr_col_r;

    // Read-side state
    logic               rsel_r;
    logic [9:0]         sprx_l_r;

    // Combinational decode
    logic               line_start_s;
    logic               swap_s;
    logic [9:0]         next_y_s;
    logic [10:0]        row_s;
    logic               row_hit_s;
    logic [ADDR_W-1:0]  base_s;
    logic [10:0]        col_s;
    logic               rd_en_s;

    // Line-start / swap decode and sprite-relative row/column arithmetic.
    always_comb begin
        line_start_s = (DrawX == 10'(H_ACTIVE));
        swap_s       = (DrawX == 10'(H_TOTAL - 1));
        if (DrawY == 10'(V_TOTAL - 1)) begin
            next_y_s = 10'd0;
        end else begin
            next_y_s = DrawY + 10'd1;
        end
        row_s     = {1'b0, next_y_s} - ({1'b0, SprY} - 11'(SPR_H / 2));
        row_hit_s = in_window(row_s, SPR_H);
        base_s    = ADDR_W'(frame_sel) * ADDR_W'(FRAME_WORDS)
                  + ADDR_W'(row_s[ROW_W-1:0]) * ADDR_W'(SPR_W);
        col_s     = {1'b0, DrawX} - ({1'b0, sprx_l_r} - 11'(SPR_W / 2));
        rd_en_s   = line_hit_r[rsel_r] & in_window(col_s, SPR_W);
    end

    // Fetch FSM: column 0 is issued on the line-start edge, the rest in FETCH.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r     <= IDLE;
            col_r       <= COL_W'(0);
            base_r      <= ADDR_W'(0);
            rom_addr_r  <= ADDR_W'(0);
            line_hit_r  <= 2'b00;
            wbank_r     <= 1'b0;
            issue_v_r   <= 1'b0;
            issue_col_r <= COL_W'(0);
        end else begin
            case (state_r)
                IDLE: begin
                    issue_v_r <= 1'b0;
                    if (line_start_s) begin
                        line_hit_r[~rsel_r] <= row_hit_s;
                        if (row_hit_s) begin
                            state_r     <= FETCH;
                            base_r      <= base_s;
                            rom_addr_r  <= base_s;
                            issue_v_r   <= 1'b1;
                            issue_col_r <= COL_W'(0);
                            col_r       <= COL_W'(1);
                            wbank_r     <= ~rsel_r;
                        end
                    end
                end
                FETCH: begin
                    rom_addr_r  <= base_r + ADDR_W'(col_r);
                    issue_v_r   <= 1'b1;
                    issue_col_r <= col_r;
                    if (col_r == COL_W'(SPR_W - 1)) begin
                        state_r <= DRAIN;
                        col_r   <= COL_W'(0);
                    end else begin
                        col_r   <= col_r + COL_W'(1);
                    end
                end
                DRAIN: begin
                    issue_v_r <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    issue_v_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    // Delay column/enable by one cycle so the write lines up with ROM data.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_v_r   <= 1'b0;
            wr_col_r <= COL_W'(0);
        end else begin
            wr_v_r   <= issue_v_r;
            wr_col_r <= issue_col_r;
        end
    end

    // Swap display bank at end of line and latch the sprite X for the new line.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rsel_r   <= 1'b0;
            sprx_l_r <= 10'd0;
        end else if (swap_s) begin
            rsel_r   <= ~rsel_r;
            sprx_l_r <= SprX;
        end
    end

    line_buffer_2x u_line_buffer (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .wr_en     (wr_v_r),
        .wr_bank   (wbank_r),
        .wr_addr   (wr_col_r),
        .wr_data   (rom_data),
        .rd_en     (rd_en_s),
        .rd_bank   (rsel_r),
        .rd_addr   (col_s[COL_W-1:0]),
        .rd_data   (pix_idx),
        .rd_opaque (pix_valid)
    );

    assign rom_addr = rom_addr_r;

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Bench for sprite_line_fetch: drives whole scanlines and checks the pixel
// stream and ROM fetch addresses against a line-level reference model.
module tb_sprite_line_fetch;

    logic        Clk;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY, SprX, SprY;
    logic [1:0]  frame_sel;
    logic [11:0] rom_addr;
    logic [3:0]  rom_data;
    logic [3:0]  pix_idx;
    logic        pix_valid;

    int checks = 0;
    int errors = 0;

    logic [3:0] rom_mem [0:4095];

    // Reference model: sprite row shown on the current line / captured for the next.
    int  cur_line  [0:31];
    int  next_line [0:31];
    bit  cur_valid, next_valid;
    int  cur_sprx;
    bit  fetch_on;
    int  fetch_base;
    bit  rom_zero;

    sprite_line_fetch dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .SprX      (SprX),
        .SprY      (SprY),
        .frame_sel (frame_sel),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pix_idx   (pix_idx),
        .pix_valid (pix_valid)
    );

    initial Clk = 1'b0;
    always #20 Clk = ~Clk;

    // Synchronous sprite ROM: data valid one clock after the address.
    always @(posedge Clk) rom_data <= rom_mem[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                       input int x, input int y);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s x=%0d y=%0d observed=%0d expected=%0d", tag, x, y, obs, exp);
        end
    endtask

    // One pixel clock: drive DrawX/DrawY, then check outputs at the falling edge.
    task automatic cyc(input int x, input int y, input bit do_rst);
        int ny, row, col;
        logic [3:0] e_idx;
        logic       e_v;
        Reset_n = do_rst ? 1'b0 : 1'b1;
        DrawX   = 10'(x);
        DrawY   = 10'(y);
        if (do_rst) begin
            cur_valid  = 1'b0;
            next_valid = 1'b0;
            cur_sprx   = 0;
            fetch_on   = 1'b0;
            rom_zero   = 1'b1;
        end else if (x == 640) begin
            ny  = (y == 524) ? 0 : y + 1;
            row = ny - (int'(SprY) - 16);
            if (row >= 0 && row < 32) begin
                next_valid = 1'b1;
                fetch_base = int'(frame_sel) * 1024 + row * 32;
                for (int c = 0; c < 32; c++) next_line[c] = int'(rom_mem[fetch_base + c]);
                fetch_on   = 1'b1;
                rom_zero   = 1'b0;
            end else begin
                next_valid = 1'b0;
            end
        end
        @(negedge Clk);
        col = x - (cur_sprx - 16);
        if (cur_valid && col >= 0 && col < 32) e_idx = 4'(cur_line[col]);
        else                                    e_idx = 4'd0;
        e_v = (e_idx != 4'd0);
        chk("pix_idx", 32'(pix_idx), 32'(e_idx), x, y);
        chk("pix_valid", 32'(pix_valid), 32'(e_v), x, y);
        if (fetch_on && x >= 640 && x <= 671)
            chk("rom_addr", 32'(rom_addr), 32'(fetch_base + x - 640), x, y);
        if (rom_zero)
            chk("rom_addr_idle", 32'(rom_addr), 32'd0, x, y);
        if (x == 671) fetch_on = 1'b0;
        if (x == 799 && !do_rst) begin
            cur_valid = next_valid;
            cur_line  = next_line;
            cur_sprx  = int'(SprX);
        end
    endtask

    task automatic run_line(input int y, input int rst_x);
        for (int x = 0; x < 800; x++) cyc(x, y, (x == rst_x));
    endtask

    initial begin
        int ry;
        Reset_n   = 1'b0;
        DrawX     = 10'd0;
        DrawY     = 10'd0;
        SprX      = 10'd0;
        SprY      = 10'd0;
        frame_sel = 2'd0;
        for (int i = 0; i < 4096; i++) rom_mem[i] = 4'((i % 15) + 1);
        cur_valid  = 1'b0;
        next_valid = 1'b0;
        cur_sprx   = 0;
        fetch_on   = 1'b0;
        fetch_base = 0;
        rom_zero   = 1'b1;
        for (int c = 0; c < 32; c++) begin
            cur_line[c]  = 0;
            next_line[c] = 0;
        end
        repeat (3) @(negedge Clk);
        chk("reset_pix_idx", 32'(pix_idx), 32'd0, 0, 0);
        chk("reset_pix_valid", 32'(pix_valid), 32'd0, 0, 0);
        chk("reset_rom_addr", 32'(rom_addr), 32'd0, 0, 0);

        // Reset mid-fetch, then recovery on the following lines.
        SprX = 10'd100; SprY = 10'd100; frame_sel = 2'd0;
        run_line(83, 650);
        run_line(84, -1);
        run_line(85, -1);

        // Sprite top row at line 84.
        run_line(83, -1);
        run_line(84, -1);

        // Bottom row from frame 2, then the line below the sprite.
        frame_sel = 2'd2;
        run_line(114, -1);
        run_line(115, -1);
        run_line(116, -1);

        // Left-clipped sprite.
        SprX = 10'd5; SprY = 10'd50; frame_sel = 2'd1;
        run_line(40, -1);
        run_line(41, -1);

        // Vertical wrap: last line fetches for line 0.
        SprX = 10'd200; SprY = 10'd8; frame_sel = 2'd0;
        run_line(524, -1);
        run_line(0, -1);

        // Transparent word inside an otherwise opaque row.
        rom_mem[10 * 32 + 3] = 4'd0;
        SprX = 10'd300; SprY = 10'd200; frame_sel = 2'd0;
        run_line(193, -1);
        run_line(194, -1);

        // Randomised positions, frames and ROM contents.
        for (int i = 0; i < 4096; i++) rom_mem[i] = 4'($urandom_range(0, 15));
        for (int n = 0; n < 12; n++) begin
            ry        = int'($urandom_range(1, 523));
            SprX      = 10'($urandom_range(0, 600));
            SprY      = 10'(ry + int'($urandom_range(0, 36)) - 2);
            frame_sel = 2'($urandom_range(0, 3));
            run_line(ry, -1);
        end
        run_line(1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
